// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and the main-memory model:
// request opcodes, main-memory FSM states and the default line geometry.
package cache_pkg;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic {
    OP_REFILL    = 1'b0,
    OP_WRITEBACK = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_DONE     = 3'd4
  } mem_state_e;

endpackage

// File: rtl/main_memory_ctrl_if.sv
// Request / burst channel between the cache controller (master) and the
// main-memory controller (slave).
interface main_memory_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              wb_done;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, wb_done, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, wb_done, busy
  );

endinterface

// File: rtl/main_memory_ctrl_mem_array.sv
// Single-port backing store: synchronous write, synchronous registered read.
// Contents are not touched by reset; only the read register is cleared.
module mem_array
  import cache_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_WORDS = 1024,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Storage write; deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read data, held between read beats and cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory controller: accepts line refills and writebacks, applies a
// fixed access latency and bursts WORDS_PER_LINE beats to/from mem_array.
// All outputs are registered.
module main_memory_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int LATENCY        = 8,
  parameter int MEM_WORDS      = 1024
) (
  input logic               clk,
  input logic               rst_n,
  main_memory_ctrl_if.slave bus
);

  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int LAT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0]  LAT_MAX    = LAT_W'(LATENCY);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORDS_PER_LINE - 1);

  mem_state_e        state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic req_ready_q, wr_ready_q, rd_valid_q, rd_last_q, wb_done_q, busy_q;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] addr_full;
  logic [MEM_AW-1:0] mem_addr;
  logic              unused_addr_hi;

  // Array address is line base plus beat; upper bits beyond the array
  // depth are dropped so out-of-range lines alias modulo MEM_WORDS.
  assign addr_full      = base_q + ADDR_W'(beat_q);
  assign mem_addr       = addr_full[MEM_AW-1:0];
  assign unused_addr_hi = ^addr_full[ADDR_W-1:MEM_AW];

  // Next-state, counters and array strobes.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d   = op_e'(bus.req_we);
          base_d = bus.req_addr & ALIGN_MASK;
          beat_d = '0;
          lat_d  = '0;
          if (bus.req_we) begin
            state_d = ST_WR_BURST;
          end else begin
            state_d = (LATENCY == 0) ? ST_RD_BURST : ST_WAIT;
          end
        end
      end
      ST_WR_BURST: begin
        if (bus.wr_valid && wr_ready_q) begin
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d = (LATENCY == 0) ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        lat_d = (lat_q == LAT_MAX) ? lat_q : lat_q + 1'b1;
        if (lat_d == LAT_MAX) begin
          state_d = (op_q == OP_WRITEBACK) ? ST_DONE : ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        // Address issued here; data surfaces from the array register next
        // cycle together with rd_valid.
        mem_re = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_REFILL;
      base_q      <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      wb_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      req_ready_q <= (state_d == ST_IDLE);
      wr_ready_q  <= (state_d == ST_WR_BURST);
      rd_valid_q  <= (state_q == ST_RD_BURST);
      rd_last_q   <= (state_q == ST_RD_BURST) && (beat_q == BEAT_LAST);
      wb_done_q   <= (state_q == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  mem_array #(
    .DATA_W   (DATA_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(bus.wr_data),
    .rdata_o(bus.rd_data)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.wb_done   = wb_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Main-memory model and controller directly downstream of the cache controller in `main`.
- Serves line refills (read bursts) and dirty-line writebacks (write bursts) over a valid/ready request channel.
- Applies a fixed access latency.
- Holds the backing store, so the cache bench runs self-contained with only clk and rst_n driven from the test bench.

Parameters:
- ADDR_W, 16, word-address width.
- DATA_W, 32, data word width.
- WORDS_PER_LINE, 4, beats per burst (power of 2, >=2).
- LATENCY, 8, access latency in cycles (0 allowed).
- MEM_WORDS, 1024, backing-store depth in words (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  0 = refill (read line), 1 = writeback (write line).
- req_addr  in  ADDR_W  word address; low log2(WORDS_PER_LINE) bits ignored (line-aligned).
- wr_data  in  DATA_W  writeback beat data.
- wr_valid  in  1  writeback beat present.
- wr_ready  out  1  controller accepts a writeback beat.
- rd_data  out  DATA_W  refill beat data.
- rd_valid  out  1  refill beat valid.
- rd_last  out  1  final refill beat.
- wb_done  out  1  one-cycle pulse when a writeback is committed.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, all counters 0, req_ready=0 during reset and 1 after release. wr_ready, rd_valid, rd_last, wb_done, busy = 0. rd_data = 0.
- Reset and memory: memory contents are not cleared by reset. Simulation initial contents are all zero.
- States: IDLE, WR_BURST, WAIT, RD_BURST, DONE.
- Request acceptance: a request is accepted on an edge where req_valid && req_ready. req_ready is high only in IDLE. Requests while busy are not accepted; the requester holds req_valid.
- Latched fields: on accept, latch op and line base = {req_addr[ADDR_W-1:log2 WPL], zeros}. Address into the array is base+beat, truncated modulo MEM_WORDS (no error on out-of-range).
- Refill path:
  - IDLE -> WAIT. WAIT counts LATENCY cycles; if LATENCY=0, go straight to RD_BURST.
  - RD_BURST emits WORDS_PER_LINE consecutive beats, one per cycle, in order beat 0..WPL-1. No critical-word-first, no back-pressure; the consumer must take every beat.
  - rd_last is high with beat WPL-1.
  - First rd_valid appears LATENCY+1 cycles after the accepting edge.
  - After the last beat, return to IDLE; req_ready is high the following cycle.
- Writeback path:
  - IDLE -> WR_BURST. wr_ready = 1 in WR_BURST only.
  - Each edge with wr_valid && wr_ready writes mem[base+beat] = wr_data and increments beat. wr_valid gaps are allowed.
  - After beat WPL-1 is accepted, go to WAIT for LATENCY cycles, then DONE.
  - DONE asserts wb_done for exactly one cycle, then returns to IDLE.
- Read-after-write: a refill issued after wb_done returns the newly written data.
- Beat counter: log2(WPL) bits, wraps to 0 at burst end. The latency counter saturates at LATENCY.
- Reset mid-operation: abort immediately to IDLE with all outputs at reset values. Writeback beats already written remain in memory; no partial rd_valid follows reset release.
- Registered outputs: every output is registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package cache_pkg:
  - op encoding OP_REFILL=0, OP_WRITEBACK=1;
  - state encoding for this FSM;
  - default WORDS_PER_LINE and DATA_W, shared with the cache controller so line geometry matches.
- One sub-module: mem_array, a single-port synchronous-read/synchronous-write RAM (MEM_WORDS x DATA_W). The FSM and counters live in main_memory_ctrl.
- Read timing: the array address is presented one cycle ahead so rd_data aligns with rd_valid.

Test Plan:
- Reset: hold rst_n=0 for 15 ns, release. Check req_ready=1 on the next edge, busy=0, rd_valid=0, wb_done=0. Assert rst_n asynchronously mid-cycle and check the outputs drop without a clock edge.
- Writeback then refill: writeback to addr 0x0040 with data 0xA0,0xA1,0xA2,0xA3. Expect wb_done pulse exactly LATENCY+1 cycles after the 4th beat is accepted. Then refill addr 0x0042 (unaligned): expect 0xA0..0xA3 in order, rd_last on 0xA3, first rd_valid 9 cycles after accept (LATENCY=8).
- Back-pressure and busy: hold req_valid high for a second refill during an active refill. It is not accepted until IDLE, then serviced. Exactly 4 beats per request, no overlap.
- Writeback gaps: wr_valid toggles 1,0,0,1,1,0,1. Exactly 4 words are written. No write occurs while wr_valid=0. wr_ready drops after the 4th beat.
- Wrap and boundary: refill addr 0xFFFC with MEM_WORDS=1024 reads words 0x3FC..0x3FF. Rerun with LATENCY=0: first rd_valid 1 cycle after accept.
- Reset mid-writeback: assert rst_n=0 after 2 of 4 beats. Check the FSM returns to IDLE, those 2 words are retained, the other 2 are unchanged, and no wb_done fires.
